// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between ex_stage and wb_stage.
// Latches the EX bus and performs at most one data-memory request per
// instruction. Load data is aligned and extended before it goes to WB, and a
// bypass bus tells ID whether the result is usable yet.
module mem_stage #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ex_to_mem_valid,
  output logic                         mem_allow_in,
  input  logic [PC_WIDTH+2*XLEN+11:0]  ex_to_mem_bus,
  input  logic                         wb_allow_in,
  output logic                         mem_to_wb_valid,
  output logic [PC_WIDTH+XLEN+6:0]     mem_to_wb_bus,
  output logic [XLEN+6:0]              mem_to_id_bus,
  output logic                         dmem_req,
  input  logic                         dmem_ready,
  output logic                         dmem_we,
  output logic [XLEN-1:0]              dmem_addr,
  output logic [3:0]                   dmem_wstrb,
  output logic [XLEN-1:0]              dmem_wdata,
  input  logic                         dmem_rvalid,
  input  logic [XLEN-1:0]              dmem_rdata,
  output logic                         mem_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t state;

  // Half-words need an even address, words need a zero byte offset.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == 2'b01) && a[0]) || (size[1] && (a != 2'b00));
  endfunction

  // Fields of the incoming EX bus, needed to decide whether to start a request.
  logic [XLEN-1:0] in_alu;
  logic            in_load, in_store;
  logic [1:0]      in_size;
  logic            latch, in_go_req;

  assign in_alu    = ex_to_mem_bus[2*XLEN+11:XLEN+12];
  assign in_load   = ex_to_mem_bus[5];
  assign in_store  = ex_to_mem_bus[4];
  assign in_size   = ex_to_mem_bus[2:1];
  assign latch     = mem_allow_in & ex_to_mem_valid;
  assign in_go_req = (in_load | in_store) & ~misaligned(in_size, in_alu[1:0]);

  // Latched instruction fields.
  logic                mem_valid;
  logic [PC_WIDTH-1:0] pc_q;
  logic [XLEN-1:0]     alu_q, sd_q, rdata_q;
  logic                wr_q, load_q, store_q, uns_q, ebreak_q;
  logic [4:0]          waddr_q;
  logic [1:0]          size_q;

  logic            is_mem, misalign_q, ready_go, rf_wr_eff, fwd_pending;
  logic [1:0]      a_q;
  logic [XLEN-1:0] shifted, load_val, final_result;

  assign a_q        = alu_q[1:0];
  assign is_mem     = load_q | store_q;
  assign misalign_q = is_mem & misaligned(size_q, a_q);
  assign ready_go   = ~is_mem | (state == S_DONE) | misalign_q;

  assign mem_allow_in    = ~mem_valid | (ready_go & wb_allow_in);
  assign mem_to_wb_valid = mem_valid & ready_go;
  assign mem_misalign    = mem_valid & misalign_q;

  // Pipeline register: take a new instruction whenever the stage can accept one.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      pc_q      <= '0;
      alu_q     <= '0;
      sd_q      <= '0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      ebreak_q  <= 1'b0;
    end else if (mem_allow_in) begin
      mem_valid <= ex_to_mem_valid;
      if (ex_to_mem_valid) begin
        {pc_q, alu_q, sd_q, wr_q, waddr_q, load_q, store_q, uns_q, size_q, ebreak_q} <= ex_to_mem_bus;
      end
    end
  end

  // Request FSM: one request per aligned memory op, response word kept until WB takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (latch && in_go_req) state <= S_REQ;
        end
        S_REQ: begin
          if (dmem_ready) begin
            if (dmem_rvalid) begin
              rdata_q <= dmem_rdata;
              state   <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            rdata_q <= dmem_rdata;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (wb_allow_in) state <= (latch && in_go_req) ? S_REQ : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory port is driven only from latched state, so it stays stable while requesting.
  assign dmem_req   = (state == S_REQ);
  assign dmem_we    = store_q;
  assign dmem_addr  = {alu_q[XLEN-1:2], 2'b00};
  assign dmem_wdata = (size_q == 2'b00) ? {(XLEN/8){sd_q[7:0]}} :
                      (size_q == 2'b01) ? {(XLEN/16){sd_q[15:0]}} : sd_q;

  // Byte enables follow the access size and the byte offset.
  always_comb begin
    dmem_wstrb = 4'b1111;
    case (size_q)
      2'b00:   dmem_wstrb = 4'b0001 << a_q;
      2'b01:   dmem_wstrb = 4'b0011 << a_q;
      default: dmem_wstrb = 4'b1111;
    endcase
  end

  // Load alignment and sign/zero extension.
  assign shifted = rdata_q >> {a_q, 3'b000};
  always_comb begin
    load_val = shifted;
    case (size_q)
      2'b00:   load_val = uns_q ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = uns_q ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  assign rf_wr_eff    = wr_q & ~store_q & ~misalign_q;
  assign final_result = misalign_q ? '0 : (load_q ? load_val : alu_q);

  assign mem_to_wb_bus = {pc_q, final_result, rf_wr_eff, waddr_q, ebreak_q};

  // A load still waiting for its data makes ID stall instead of forwarding.
  assign fwd_pending   = mem_valid & load_q & ~misalign_q & (state != S_DONE);
  assign mem_to_id_bus = {mem_valid & rf_wr_eff,
                          mem_valid ? waddr_q : 5'd0,
                          fwd_pending,
                          (mem_valid & ~fwd_pending) ? final_result : {XLEN{1'b0}}};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test of mem_stage with hand-computed expectations.
module tb_mem_stage;

  localparam int XLEN = 32;
  localparam int PCW  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_to_mem_valid;
  logic             mem_allow_in;
  logic [PCW+2*XLEN+11:0] ex_to_mem_bus;
  logic             wb_allow_in;
  logic             mem_to_wb_valid;
  logic [PCW+XLEN+6:0] mem_to_wb_bus;
  logic [XLEN+6:0]  mem_to_id_bus;
  logic             dmem_req, dmem_ready, dmem_we, dmem_rvalid, mem_misalign;
  logic [XLEN-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]       dmem_wstrb;

  int checks   = 0;
  int failures = 0;
  int req_count = 0;
  int wb_count  = 0;
  int snap;

  mem_stage #(.XLEN(XLEN), .PC_WIDTH(PCW)) dut (
    .clk(clk), .rst(rst),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allow_in(mem_allow_in),
    .ex_to_mem_bus(ex_to_mem_bus), .wb_allow_in(wb_allow_in),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_bus(mem_to_wb_bus),
    .mem_to_id_bus(mem_to_id_bus),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_misalign(mem_misalign)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count accepted requests and WB handoffs at each active edge.
  always @(posedge clk) begin
    if (!rst && dmem_req && dmem_ready) req_count++;
    if (!rst && mem_to_wb_valid && wb_allow_in) wb_count++;
  end

  function automatic logic [PCW+2*XLEN+11:0] mkEx(
      input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
      input logic wr, input logic [4:0] waddr, input logic ld, input logic st,
      input logic uns, input logic [1:0] size, input logic eb);
    return {pc, alu, sd, wr, waddr, ld, st, uns, size, eb};
  endfunction

  function automatic logic [PCW+XLEN+6:0] mkWb(
      input logic [31:0] pc, input logic [31:0] res, input logic wr,
      input logic [4:0] waddr, input logic eb);
    return {pc, res, wr, waddr, eb};
  endfunction

  function automatic logic [XLEN+6:0] mkId(
      input logic wr, input logic [4:0] waddr, input logic pend, input logic [31:0] data);
    return {wr, waddr, pend, data};
  endfunction

  task automatic applyStimulus(input logic v, input logic [PCW+2*XLEN+11:0] bus,
                               input logic wba, input logic rdy, input logic rv,
                               input logic [31:0] rd);
    @(negedge clk);
    ex_to_mem_valid = v;
    ex_to_mem_bus   = bus;
    wb_allow_in     = wba;
    dmem_ready      = rdy;
    dmem_rvalid     = rv;
    dmem_rdata      = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_to_mem_valid = 1'b0;
    ex_to_mem_bus   = '0;
    wb_allow_in     = 1'b1;
    dmem_ready      = 1'b0;
    dmem_rvalid     = 1'b0;
    dmem_rdata      = '0;
    repeat (2) @(posedge clk);

    // Reset state
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_wb_valid", mem_to_wb_valid, 0);
    checkOutput("rst_allow_in", mem_allow_in, 1);
    checkOutput("rst_req", dmem_req, 0);
    checkOutput("rst_misalign", mem_misalign, 0);
    checkOutput("rst_id_bus", mem_to_id_bus, 0);
    rst = 1'b0;

    // ALU op, zero extra latency
    applyStimulus(1'b1, mkEx(32'h100, 32'h55, 32'h0, 1, 5'd5, 0, 0, 0, 2'b10, 0), 1'b1, 0, 0, 32'h0);
    checkOutput("alu_allow_in", mem_allow_in, 1);
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("alu_wb_valid", mem_to_wb_valid, 1);
    checkOutput("alu_wb_bus", mem_to_wb_bus, mkWb(32'h100, 32'h55, 1, 5'd5, 0));
    checkOutput("alu_id_bus", mem_to_id_bus, mkId(1, 5'd5, 0, 32'h55));

    // lb 0x1003, ready+rvalid together
    applyStimulus(1'b1, mkEx(32'h200, 32'h1003, 32'h0, 1, 5'd7, 1, 0, 0, 2'b00, 0), 1'b1, 0, 0, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 1, 1, 32'h80AABBCC);
    checkOutput("lb_req", dmem_req, 1);
    checkOutput("lb_addr", dmem_addr, 32'h1000);
    checkOutput("lb_we", dmem_we, 0);
    checkOutput("lb_wb_valid_early", mem_to_wb_valid, 0);
    checkOutput("lb_pending", mem_to_id_bus[XLEN+6:XLEN], {1'b1, 5'd7, 1'b1});
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("lb_wb_valid", mem_to_wb_valid, 1);
    checkOutput("lb_wb_bus", mem_to_wb_bus, mkWb(32'h200, 32'hFFFFFF80, 1, 5'd7, 0));
    checkOutput("lb_req_off", dmem_req, 0);

    // lbu 0x1003
    applyStimulus(1'b1, mkEx(32'h204, 32'h1003, 32'h0, 1, 5'd8, 1, 0, 1, 2'b00, 0), 1'b1, 0, 0, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 1, 1, 32'h80AABBCC);
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("lbu_wb_valid", mem_to_wb_valid, 1);
    checkOutput("lbu_wb_bus", mem_to_wb_bus, mkWb(32'h204, 32'h80, 1, 5'd8, 0));

    // sh 0x2002, request held three cycles before acceptance
    snap = req_count;
    applyStimulus(1'b1, mkEx(32'h208, 32'h2002, 32'h1234, 1, 5'd3, 0, 1, 0, 2'b01, 0), 1'b1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
      checkOutput("sh_req_held", dmem_req, 1);
      checkOutput("sh_wstrb", dmem_wstrb, 4'b1100);
      checkOutput("sh_wdata", dmem_wdata, 32'h12341234);
      checkOutput("sh_we", dmem_we, 1);
      checkOutput("sh_addr", dmem_addr, 32'h2000);
      checkOutput("sh_wb_valid_early", mem_to_wb_valid, 0);
    end
    applyStimulus(1'b0, '0, 1'b1, 1, 0, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("sh_wait_req", dmem_req, 0);
    checkOutput("sh_wait_valid", mem_to_wb_valid, 0);
    applyStimulus(1'b0, '0, 1'b1, 0, 1, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("sh_wb_valid", mem_to_wb_valid, 1);
    checkOutput("sh_wb_bus", mem_to_wb_bus, mkWb(32'h208, 32'h2002, 0, 5'd3, 0));
    checkOutput("sh_req_count", req_count, snap + 1);

    // lw 0x3000 completes while WB is stalled for two cycles
    applyStimulus(1'b1, mkEx(32'h20C, 32'h3000, 32'h0, 1, 5'd9, 1, 0, 0, 2'b10, 0), 1'b1, 0, 0, 32'h0);
    applyStimulus(1'b0, '0, 1'b0, 1, 1, 32'hDEADBEEF);
    snap = wb_count;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 0, 0, 32'h0);
      checkOutput("hold_wb_valid", mem_to_wb_valid, 1);
      checkOutput("hold_allow_in", mem_allow_in, 0);
      checkOutput("hold_wb_bus", mem_to_wb_bus, mkWb(32'h20C, 32'hDEADBEEF, 1, 5'd9, 0));
      checkOutput("hold_id_bus", mem_to_id_bus, mkId(1, 5'd9, 0, 32'hDEADBEEF));
    end
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("hold_wb_valid_after", mem_to_wb_valid, 0);
    checkOutput("hold_wb_once", wb_count, snap + 1);

    // lw 0x3002 misaligned: no request, WB gets no write
    snap = req_count;
    applyStimulus(1'b1, mkEx(32'h210, 32'h3002, 32'h0, 1, 5'd10, 1, 0, 0, 2'b10, 0), 1'b1, 0, 0, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("mis_flag", mem_misalign, 1);
    checkOutput("mis_req", dmem_req, 0);
    checkOutput("mis_wb_valid", mem_to_wb_valid, 1);
    checkOutput("mis_wb_bus", mem_to_wb_bus, mkWb(32'h210, 32'h0, 0, 5'd10, 0));
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("mis_flag_clear", mem_misalign, 0);
    checkOutput("mis_req_count", req_count, snap);

    // Reset during WAIT, then a late response
    applyStimulus(1'b1, mkEx(32'h214, 32'h4000, 32'h0, 1, 5'd11, 1, 0, 0, 2'b10, 0), 1'b1, 0, 0, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 1, 0, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("rstw_req", dmem_req, 0);
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 0, 1, 32'hCAFEF00D);
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("rstw_wb_valid", mem_to_wb_valid, 0);
    checkOutput("rstw_req_idle", dmem_req, 0);
    checkOutput("rstw_allow_in", mem_allow_in, 1);
    checkOutput("rstw_id_bus", mem_to_id_bus, 0);

    // ebreak ALU op after reset passes through unchanged
    applyStimulus(1'b1, mkEx(32'h218, 32'h77, 32'h0, 0, 5'd0, 0, 0, 0, 2'b10, 1), 1'b1, 0, 0, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 0, 0, 32'h0);
    checkOutput("eb_wb_valid", mem_to_wb_valid, 1);
    checkOutput("eb_wb_bus", mem_to_wb_bus, mkWb(32'h218, 32'h77, 0, 5'd0, 1));
    checkOutput("eb_req", dmem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
